load_store_unit: RTL and testbench

- Sits between the core's memory stage and the 256x32 word RAM.
- Converts byte-addressed RV32I loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) into RAM word accesses.
- The RAM has no byte enables, so sub-word stores use read-modify-write.
- Handles the RAM's 1-cycle registered read latency, sign/zero extension and misalignment errors.

---
 rtl/myrv_mem_pkg.sv | 16 +
 rtl/lsu_align.sv | 44 ++++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/myrv_mem_pkg.sv
// Shared encodings for the load/store path: access sizes and LSU FSM states.
// Imported by the alignment datapath and the load/store unit.
package myrv_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        EXT,
        WR
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction, sign/zero extension, sub-word merge and alignment check.
// Purely combinational; shared by the load and read-modify-write paths.
module lsu_align
    import myrv_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_result,
    output logic [31:0] merged_word,
    output logic        misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word[{lane, 3'b000} +: 8];
    assign half_v = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_result = word;
        merged_word = word;
        misaligned  = 1'b0;
        unique case (1'b1)
            (size == SZ_B): begin
                load_result = {{24{~zext & byte_v[7]}}, byte_v};
                merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            (size == SZ_H): begin
                load_result = {{16{~zext & half_v[15]}}, half_v};
                merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                misaligned = lane[0];
            end
            (size == SZ_W): begin
                merged_word = wdata;
                misaligned  = (lane != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end for a word RAM without byte
// enables; sub-word stores are done as read-modify-write.
module load_store_unit
    import myrv_mem_pkg::*;
#(
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [RAM_AW-1:0] ram_read_addr,
    output logic [RAM_AW-1:0] ram_write_addr,
    output logic              ram_mem_read,
    output logic              ram_mem_write,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out
);

    lsu_state_t        state_q;
    lsu_state_t        state_d;
    logic              cap_write;
    logic [1:0]        cap_size;
    logic              cap_zext;
    logic [1:0]        cap_lane;
    logic [RAM_AW-1:0] cap_word;
    logic [31:0]       cap_wdata;

    logic              idle;
    logic              accept;
    logic              bad;
    logic [1:0]        al_size;
    logic [1:0]        al_lane;
    logic [31:0]       load_result;
    logic [31:0]       merged_word;
    logic              misaligned;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:RAM_AW+2];

    assign idle      = (state_q == IDLE);
    assign req_ready = idle;
    assign accept    = req_valid && idle;
    assign bad       = accept && misaligned;

    // In IDLE the aligner checks the incoming request; later it works on
    // the captured one.
    assign al_size = idle ? req_size      : cap_size;
    assign al_lane = idle ? req_addr[1:0] : cap_lane;

    lsu_align u_align (
        .size        (al_size),
        .zext        (cap_zext),
        .lane        (al_lane),
        .word        (ram_data_out),
        .wdata       (cap_wdata),
        .load_result (load_result),
        .merged_word (merged_word),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write <= req_write;
            cap_size  <= req_size;
            cap_zext  <= req_unsigned;
            cap_lane  <= req_addr[1:0];
            cap_word  <= req_addr[RAM_AW+1:2];
            cap_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state_q    <= state_d;
            resp_valid <= (state_q == WR) || (state_q == EXT) || bad;
            resp_err   <= bad;
            resp_rdata <= (state_q == EXT && !cap_write) ? load_result : '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        ram_mem_read  = 1'b0;
        ram_mem_write = 1'b0;
        ram_data_in   = merged_word;
        unique case (state_q)
            IDLE: begin
                if (accept && !misaligned) begin
                    if (req_write && req_size == SZ_W) state_d = WR;
                    else                               state_d = RD;
                end
            end
            RD: begin
                ram_mem_read = !rst;
                state_d      = EXT;
            end
            EXT: begin
                ram_mem_write = !rst && cap_write;
                state_d       = IDLE;
            end
            WR: begin
                ram_mem_write = !rst;
                ram_data_in   = cap_wdata;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_read_addr  = cap_word;
    assign ram_write_addr = cap_word;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 256x32 registered RAM.
// Checks latency, data, error flag and RAM traffic per request.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  ram_read_addr;
    logic [7:0]  ram_write_addr;
    logic        ram_mem_read;
    logic        ram_mem_write;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;

    logic [31:0] mem [256];
    int          tests = 0;
    int          fails = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          resp_cnt = 0;
    logic [7:0]  last_wa = '0;

    always #5 clk = ~clk;

    load_store_unit #(.RAM_AW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_rdata     (resp_rdata),
        .ram_read_addr  (ram_read_addr),
        .ram_write_addr (ram_write_addr),
        .ram_mem_read   (ram_mem_read),
        .ram_mem_write  (ram_mem_write),
        .ram_data_in    (ram_data_in),
        .ram_data_out   (ram_data_out)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_data_out = '0;
    end

    always @(posedge clk) begin
        if (ram_mem_read) ram_data_out <= mem[ram_read_addr];
        if (ram_mem_write) mem[ram_write_addr] <= ram_data_in;
    end

    always @(negedge clk) begin
        if (ram_mem_write) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= ram_write_addr;
        end
        if (ram_mem_read) rd_cnt <= rd_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic w,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_wr,
                          input int exp_rds);
        int w0, r0, lat;
        logic busy_ok;
        @(negedge clk);
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        #3;
        w0 = wr_cnt;
        r0 = rd_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
            if (resp_valid) break;
            if (req_ready) busy_ok = 1'b0;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, " err"}, {31'b0, resp_err}, {31'b0, exp_err});
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " writes"}, wr_cnt - w0, exp_wr);
        chk({tag, " reads"}, rd_cnt - r0, exp_rds);
        if (exp_wr > 0)
            chk({tag, " waddr"}, {24'b0, last_wa}, {24'b0, addr[9:2]});
    endtask

    initial begin
        int w0, c0;
        #2;
        chk("rst mem_read", {31'b0, ram_mem_read}, 32'd0);
        chk("rst mem_write", {31'b0, ram_mem_write}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b0;

        do_req("sw4", 1, 2'b10, 0, 32'h4, 32'h11223344, 2, 0, 0, 1, 0);
        do_req("lw4", 0, 2'b10, 0, 32'h4, 0, 3, 0, 32'h11223344, 0, 1);
        do_req("sb5", 1, 2'b00, 0, 32'h5, 32'h000000AB, 3, 0, 0, 1, 1);
        do_req("lw4b", 0, 2'b10, 0, 32'h4, 0, 3, 0, 32'h1122AB44, 0, 1);
        do_req("lb5", 0, 2'b00, 0, 32'h5, 0, 3, 0, 32'hFFFFFFAB, 0, 1);
        do_req("lbu5", 0, 2'b00, 1, 32'h5, 0, 3, 0, 32'h000000AB, 0, 1);
        do_req("lh6", 0, 2'b01, 0, 32'h6, 0, 3, 0, 32'h00001122, 0, 1);
        do_req("lhu4", 0, 2'b01, 1, 32'h4, 0, 3, 0, 32'h0000AB44, 0, 1);
        do_req("lh4", 0, 2'b01, 0, 32'h4, 0, 3, 0, 32'hFFFFAB44, 0, 1);
        do_req("lwu4", 0, 2'b10, 1, 32'h4, 0, 3, 0, 32'h1122AB44, 0, 1);
        do_req("shA", 1, 2'b01, 0, 32'hA, 32'h1234BEEF, 3, 0, 0, 1, 1);
        do_req("lw8", 0, 2'b10, 0, 32'h8, 0, 3, 0, 32'hBEEF0000, 0, 1);
        do_req("lbB", 0, 2'b00, 0, 32'hB, 0, 3, 0, 32'hFFFFFFBE, 0, 1);
        do_req("sb7", 1, 2'b00, 0, 32'h7, 32'hFFFFFF5A, 3, 0, 0, 1, 1);
        do_req("lb7", 0, 2'b00, 0, 32'h7, 0, 3, 0, 32'h0000005A, 0, 1);
        do_req("sb7r", 1, 2'b00, 0, 32'h7, 32'h00000011, 3, 0, 0, 1, 1);

        do_req("sh3", 1, 2'b01, 0, 32'h3, 32'hFFFF, 1, 1, 0, 0, 0);
        do_req("lw2", 0, 2'b10, 0, 32'h2, 0, 1, 1, 0, 0, 0);
        do_req("sz11", 0, 2'b11, 0, 32'h0, 0, 1, 1, 0, 0, 0);
        do_req("lh1", 0, 2'b01, 0, 32'h1, 0, 1, 1, 0, 0, 0);

        // SB 0xFF to 0x4 with reset held through the EXT cycle.
        @(negedge clk);
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h4;
        req_wdata = 32'hFF;
        req_valid = 1'b1;
        #3;
        w0 = wr_cnt;
        c0 = resp_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("rstext writes", wr_cnt - w0, 0);
        chk("rstext resp", resp_cnt - c0, 0);
        chk("rstext ready", {31'b0, req_ready}, 32'd1);
        do_req("lw4c", 0, 2'b10, 0, 32'h4, 0, 3, 0, 32'h1122AB44, 0, 1);

        // Word store to word 0, then LW 0x400 held pending to alias word 0.
        @(negedge clk);
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h0;
        req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        req_addr  = 32'h400;
        req_wdata = '0;
        @(negedge clk);
        #1;
        chk("b2b c1 ready", {31'b0, req_ready}, 32'd0);
        chk("b2b c1 write", {31'b0, ram_mem_write}, 32'd1);
        @(negedge clk);
        #1;
        chk("b2b c2 resp", {31'b0, resp_valid}, 32'd1);
        chk("b2b c2 ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("b2b c3 ready", {31'b0, req_ready}, 32'd0);
        chk("b2b c3 read", {31'b0, ram_mem_read}, 32'd1);
        chk("b2b c3 raddr", {24'b0, ram_read_addr}, 32'd0);
        @(negedge clk);
        #1;
        chk("b2b c4 ready", {31'b0, req_ready}, 32'd0);
        chk("b2b c4 resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("b2b c5 resp", {31'b0, resp_valid}, 32'd1);
        chk("b2b c5 rdata", resp_rdata, 32'hCAFEF00D);
        chk("b2b c5 err", {31'b0, resp_err}, 32'd0);
        @(negedge clk);
        #1;
        chk("b2b pulse", {31'b0, resp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
